cc_ubicacion_controller: RTL and testbench

Sequential stage directly upstream of the position-select multiplexer in the LED-matrix game datapath.
- Holds the player's one-hot location register and moves it on left/right button presses.
- Generates the 2-bit select that steers the mux:
  - select 0 shows the location bus;
  - select 1 shows the blank ("nada") bus.
- On a collision ("hit") it blinks the player by toggling select for a fixed number of periods, then re-centres the player.

---
 rtl/cc_ubicacion_controller_if.sv | 39 +++
 rtl/cc_ubicacion_controller.sv | 121 ++++++++++++
 tb/tb_cc_ubicacion_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_ubicacion_controller_if.sv
// rtl/cc_ubicacion_controller_if.sv - button/hit inputs and location/select/busy outputs of the player controller
//
// Ports (signals carried):
//   CC_UBICACION_left_InHigh    left button level (debounced)
//   CC_UBICACION_right_InHigh   right button level (debounced)
//   CC_UBICACION_hit_InHigh     collision flag
//   CC_UBICACION_OutBUS         one-hot player location
//   CC_UBICACION_select_OutBUS  downstream mux select (0 = location, 1 = blank)
//   CC_UBICACION_busy_Out       blink sequence in progress
// Modports: master drives buttons/hit, slave (the controller) drives outputs.
interface cc_ubicacion_controller_if #(
    parameter int UBICACION_WIDTH = 8,
    parameter int SELECT_WIDTH    = 2
);
    logic                       CC_UBICACION_left_InHigh;
    logic                       CC_UBICACION_right_InHigh;
    logic                       CC_UBICACION_hit_InHigh;
    logic [UBICACION_WIDTH-1:0] CC_UBICACION_OutBUS;
    logic [SELECT_WIDTH-1:0]    CC_UBICACION_select_OutBUS;
    logic                       CC_UBICACION_busy_Out;

    modport master (
        output CC_UBICACION_left_InHigh,
        output CC_UBICACION_right_InHigh,
        output CC_UBICACION_hit_InHigh,
        input  CC_UBICACION_OutBUS,
        input  CC_UBICACION_select_OutBUS,
        input  CC_UBICACION_busy_Out
    );

    modport slave (
        input  CC_UBICACION_left_InHigh,
        input  CC_UBICACION_right_InHigh,
        input  CC_UBICACION_hit_InHigh,
        output CC_UBICACION_OutBUS,
        output CC_UBICACION_select_OutBUS,
        output CC_UBICACION_busy_Out
    );
endinterface

// File: rtl/cc_ubicacion_controller.sv
// rtl/cc_ubicacion_controller.sv - player location register with edge-triggered moves and post-hit blink sequencer
//
// Ports:
//   CC_UBICACION_CLOCK_50      system clock, rising edge
//   CC_UBICACION_RESET_InHigh  synchronous active-high reset
//   bus (slave)                buttons/hit in; location, mux select, busy out
module cc_ubicacion_controller #(
    parameter int UBICACION_WIDTH = 8,
    parameter int SELECT_WIDTH    = 2,
    parameter int TICK_DIV        = 25000000,
    parameter int BLINK_COUNT     = 3,
    parameter int START_POS       = 3
) (
    input  logic                        CC_UBICACION_CLOCK_50,
    input  logic                        CC_UBICACION_RESET_InHigh,
    cc_ubicacion_controller_if.slave    bus
);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int BLINK_W = $clog2(BLINK_COUNT + 1);

    localparam logic [UBICACION_WIDTH-1:0] START_ONEHOT = UBICACION_WIDTH'(1) << START_POS;
    localparam logic [TICK_W-1:0]          TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0]         BLINK_LAST   = BLINK_W'(BLINK_COUNT);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        BLINK_OFF = 2'd1,
        BLINK_ON  = 2'd2
    } state_t;

    state_t                     state;
    logic [TICK_W-1:0]          tick_cnt;
    logic [BLINK_W-1:0]         blink_cnt;
    logic                       left_prev;
    logic                       right_prev;
    logic [UBICACION_WIDTH-1:0] location;
    logic                       select_bit;
    logic                       busy;

    logic               left_press;
    logic               right_press;
    logic [BLINK_W-1:0] blink_next;

    assign left_press  = bus.CC_UBICACION_left_InHigh  & ~left_prev;
    assign right_press = bus.CC_UBICACION_right_InHigh & ~right_prev;
    assign blink_next  = blink_cnt + 1'b1;

    always_ff @(posedge CC_UBICACION_CLOCK_50) begin
        if (CC_UBICACION_RESET_InHigh) begin
            state      <= PLAY;
            tick_cnt   <= '0;
            blink_cnt  <= '0;
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            location   <= START_ONEHOT;
            select_bit <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Button history tracks in every state so a press held across
            // the end of a blink does not register as a new press.
            left_prev  <= bus.CC_UBICACION_left_InHigh;
            right_prev <= bus.CC_UBICACION_right_InHigh;

            case (state)
                PLAY: begin
                    if (bus.CC_UBICACION_hit_InHigh) begin
                        state      <= BLINK_OFF;
                        tick_cnt   <= '0;
                        blink_cnt  <= '0;
                        select_bit <= 1'b1;
                        busy       <= 1'b1;
                    end else if (left_press && !right_press) begin
                        // Saturate at the MSB column instead of wrapping.
                        if (!location[UBICACION_WIDTH-1])
                            location <= location << 1;
                    end else if (right_press && !left_press) begin
                        if (!location[0])
                            location <= location >> 1;
                    end
                end

                BLINK_OFF: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt   <= '0;
                        state      <= BLINK_ON;
                        select_bit <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                BLINK_ON: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt  <= '0;
                        blink_cnt <= blink_next;
                        if (blink_next == BLINK_LAST) begin
                            state    <= PLAY;
                            busy     <= 1'b0;
                            location <= START_ONEHOT;
                        end else begin
                            state      <= BLINK_OFF;
                            select_bit <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= PLAY;
                    select_bit <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_UBICACION_OutBUS        = location;
    assign bus.CC_UBICACION_select_OutBUS = SELECT_WIDTH'(select_bit);
    assign bus.CC_UBICACION_busy_Out      = busy;
endmodule

// File: tb/tb_cc_ubicacion_controller.sv
// tb/tb_cc_ubicacion_controller.sv - randomized and directed self-checking bench for cc_ubicacion_controller
module tb_cc_ubicacion_controller;
    localparam int W   = 8;
    localparam int SW  = 2;
    localparam int TD  = 4;
    localparam int BC  = 2;
    localparam int SP  = 3;
    localparam int LEN = 2 * TD * BC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cc_ubicacion_controller_if #(.UBICACION_WIDTH(W), .SELECT_WIDTH(SW)) bus ();

    cc_ubicacion_controller #(
        .UBICACION_WIDTH(W),
        .SELECT_WIDTH   (SW),
        .TICK_DIV       (TD),
        .BLINK_COUNT    (BC),
        .START_POS      (SP)
    ) dut (
        .CC_UBICACION_CLOCK_50    (clk),
        .CC_UBICACION_RESET_InHigh(rst),
        .bus                      (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: player column index and position within the blink
    // sequence (0 = playing, 1..LEN = cycle number since the hit).
    int m_pos = SP;
    int m_blink = 0;
    bit m_lp = 0;
    bit m_rp = 0;

    logic [W-1:0]  exp_loc;
    logic [SW-1:0] exp_sel;
    logic          exp_busy;

    function automatic void model_outputs();
        exp_loc  = W'(1) << m_pos;
        exp_busy = (m_blink != 0);
        exp_sel  = (m_blink != 0 && (((m_blink - 1) / TD) % 2) == 0) ? SW'(1) : SW'(0);
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and
    // leave time 1ns after the edge for sampling.
    task automatic step(input bit l, input bit r, input bit h, input bit rs);
        @(negedge clk);
        bus.CC_UBICACION_left_InHigh  = l;
        bus.CC_UBICACION_right_InHigh = r;
        bus.CC_UBICACION_hit_InHigh   = h;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            m_pos = SP; m_blink = 0; m_lp = 0; m_rp = 0;
        end else begin
            if (m_blink == 0) begin
                if (h) m_blink = 1;
                else if (l && !m_lp && !(r && !m_rp)) begin
                    if (m_pos < W - 1) m_pos++;
                end else if (r && !m_rp && !(l && !m_lp)) begin
                    if (m_pos > 0) m_pos--;
                end
            end else if (m_blink == LEN) begin
                m_blink = 0;
                m_pos = SP;
            end else begin
                m_blink++;
            end
            m_lp = l; m_rp = r;
        end
        model_outputs();
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h08) begin
            tests_failed++; $display("FAIL reset_loc got=%h exp=08", bus.CC_UBICACION_OutBUS);
        end
        tests_run++;
        if (bus.CC_UBICACION_select_OutBUS !== 2'd0) begin
            tests_failed++; $display("FAIL reset_sel got=%0d exp=0", bus.CC_UBICACION_select_OutBUS);
        end
        tests_run++;
        if (bus.CC_UBICACION_busy_Out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.CC_UBICACION_busy_Out);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            tests_run++;
            if (bus.CC_UBICACION_OutBUS !== 8'h08 || bus.CC_UBICACION_select_OutBUS !== 2'd0
                || bus.CC_UBICACION_busy_Out !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_hold cyc=%0d loc=%h sel=%0d busy=%b exp=08/0/0", i,
                         bus.CC_UBICACION_OutBUS, bus.CC_UBICACION_select_OutBUS, bus.CC_UBICACION_busy_Out);
            end
        end
    endtask

    task automatic test_left_moves();
        logic [W-1:0] want [3];
        want[0] = 8'h10; want[1] = 8'h20; want[2] = 8'h40;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            tests_run++;
            if (bus.CC_UBICACION_OutBUS !== want[i]) begin
                tests_failed++; $display("FAIL left_pulse%0d got=%h exp=%h", i, bus.CC_UBICACION_OutBUS, want[i]);
            end
            step(0, 0, 0, 0);
        end
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h80) begin
            tests_failed++; $display("FAIL left_held got=%h exp=80", bus.CC_UBICACION_OutBUS);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h80) begin
            tests_failed++; $display("FAIL sat_msb got=%h exp=80", bus.CC_UBICACION_OutBUS);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h01) begin
            tests_failed++; $display("FAIL sat_lsb got=%h exp=01", bus.CC_UBICACION_OutBUS);
        end
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h08) begin
            tests_failed++; $display("FAIL both_press got=%h exp=08", bus.CC_UBICACION_OutBUS);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic check_blink_window(input string tag);
        for (int k = 1; k <= LEN; k++) begin
            logic [SW-1:0] want_sel;
            want_sel = ((((k - 1) / TD) % 2) == 0) ? SW'(1) : SW'(0);
            tests_run++;
            if (bus.CC_UBICACION_select_OutBUS !== want_sel || bus.CC_UBICACION_busy_Out !== 1'b1
                || bus.CC_UBICACION_OutBUS !== 8'h20) begin
                tests_failed++;
                $display("FAIL %s T+%0d sel=%0d busy=%b loc=%h exp=%0d/1/20", tag, k,
                         bus.CC_UBICACION_select_OutBUS, bus.CC_UBICACION_busy_Out,
                         bus.CC_UBICACION_OutBUS, want_sel);
            end
            // Extra hit at T+3 and a left press held from T+6 on must be ignored.
            step(k >= 6, 0, k == 3, 0);
        end
        tests_run++;
        if (bus.CC_UBICACION_busy_Out !== 1'b0 || bus.CC_UBICACION_select_OutBUS !== 2'd0
            || bus.CC_UBICACION_OutBUS !== 8'h08) begin
            tests_failed++;
            $display("FAIL %s_end busy=%b sel=%0d loc=%h exp=0/0/08", tag,
                     bus.CC_UBICACION_busy_Out, bus.CC_UBICACION_select_OutBUS, bus.CC_UBICACION_OutBUS);
        end
    endtask

    task automatic test_blink();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);              // hit during cycle T
        check_blink_window("blink");
        step(1, 0, 0, 0);              // left still held after return to PLAY
        step(1, 0, 0, 0);
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h08) begin
            tests_failed++; $display("FAIL held_after_blink got=%h exp=08", bus.CC_UBICACION_OutBUS);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_blink();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int k = 1; k < 6; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);              // reset during T+6
        tests_run++;
        if (bus.CC_UBICACION_OutBUS !== 8'h08 || bus.CC_UBICACION_select_OutBUS !== 2'd0
            || bus.CC_UBICACION_busy_Out !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_blink_reset loc=%h sel=%0d busy=%b exp=08/0/0",
                     bus.CC_UBICACION_OutBUS, bus.CC_UBICACION_select_OutBUS, bus.CC_UBICACION_busy_Out);
        end
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_blink_window("restart");
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit l, r, h, rs;
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 149) == 0);
            step(l, r, h, rs);
            tests_run++;
            if (bus.CC_UBICACION_OutBUS !== exp_loc || bus.CC_UBICACION_select_OutBUS !== exp_sel
                || bus.CC_UBICACION_busy_Out !== exp_busy) begin
                tests_failed++;
                $display("FAIL random cyc=%0d loc=%h sel=%0d busy=%b exp=%h/%0d/%b", i,
                         bus.CC_UBICACION_OutBUS, bus.CC_UBICACION_select_OutBUS, bus.CC_UBICACION_busy_Out,
                         exp_loc, exp_sel, exp_busy);
            end
        end
    endtask

    initial begin
        bus.CC_UBICACION_left_InHigh  = 1'b0;
        bus.CC_UBICACION_right_InHigh = 1'b0;
        bus.CC_UBICACION_hit_InHigh   = 1'b0;
        test_reset();
        test_left_moves();
        test_saturation();
        test_blink();
        test_reset_mid_blink();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
